// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared byte-lane constants and write-merge helpers for reg_file_mwnr
package reg_file_pkg;
  localparam int BW = 8;
  localparam int MAXNW = 16;
  typedef struct packed {
    logic [BW-1:0] data;
    logic          en;
  } lane_t;
  function automatic logic [BW-1:0] merge_bytes(input logic [BW-1:0] old, input logic [BW-1:0] nw, input logic be);
    return be ? nw : old;
  endfunction
  // Ports are scanned upward so the highest-index enabled writer owns the lane
  function automatic lane_t resolve_writes(input logic [MAXNW-1:0] hit, input logic [MAXNW-1:0][BW-1:0] d);
    lane_t l;
    l = '0;
    for (int p = 0; p < MAXNW; p++) if (hit[p]) l = '{data: d[p], en: 1'b1};
    return l;
  endfunction
endpackage

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: per-register busy bits, set by alloc and cleared by writeback
module reg_file_scoreboard #(
  parameter int M = 8,
  parameter int AW = 3,
  parameter int NW = 2,
  parameter int ZERO_REG = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NW-1:0]    we,
  input  logic [NW*AW-1:0] waddr,
  input  logic             alloc,
  input  logic [AW-1:0]    alloc_addr,
  output logic [M-1:0]     busy,
  output logic [M-1:0]     busy_nxt
);
  localparam logic [AW:0] MV = (AW+1)'(M);
  always_comb begin
    busy_nxt = busy;
    for (int p = 0; p < NW; p++)
      if (we[p] && {1'b0, waddr[p*AW +: AW]} < MV) busy_nxt[waddr[p*AW +: AW]] = 1'b0;
    if (alloc && {1'b0, alloc_addr} < MV) busy_nxt[alloc_addr] = 1'b1;
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) busy <= '0;
    else busy <= busy_nxt;
endmodule

// File: rtl/reg_file_mwnr.sv
// reg_file_mwnr: NW-write/NR-read register file with byte enables, bypass and busy scoreboard
module reg_file_mwnr import reg_file_pkg::*; #(
  parameter int M = 8,
  parameter int N = 8,
  parameter int NR = 2,
  parameter int NW = 2,
  parameter int READ_REG = 1,
  parameter int BYPASS = 1,
  parameter int ZERO_REG = 0,
  localparam int AW = $clog2(M),
  localparam int NB = N / BW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NW-1:0]    we,
  input  logic [NW*AW-1:0] waddr,
  input  logic [NW*N-1:0]  wdata,
  input  logic [NW*NB-1:0] wbe,
  input  logic [NR-1:0]    re,
  input  logic [NR*AW-1:0] raddr,
  output logic [NR*N-1:0]  rdata,
  output logic [NR-1:0]    rvalid,
  output logic [NR-1:0]    rbusy,
  input  logic             alloc,
  input  logic [AW-1:0]    alloc_addr,
  output logic [M-1:0]     busy
);
  localparam logic [AW:0] MV = (AW+1)'(M);
  logic [N-1:0] mem [M];
  logic [N-1:0] nxt [M];
  logic [M-1:0] busy_nxt;
  logic [MAXNW-1:0] hit;
  logic [MAXNW-1:0][BW-1:0] d;
  lane_t lane;
  logic [AW-1:0] a;
  logic [NR*N-1:0] val;
  logic [NR-1:0] rb;
  reg_file_scoreboard #(.M(M), .AW(AW), .NW(NW), .ZERO_REG(ZERO_REG)) u_sb (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .alloc(alloc), .alloc_addr(alloc_addr),
    .busy(busy), .busy_nxt(busy_nxt)
  );
  always_comb begin
    hit = '0;
    d = '0;
    lane = '0;
    for (int i = 0; i < M; i++) begin
      nxt[i] = mem[i];
      for (int b = 0; b < NB; b++) begin
        hit = '0;
        d = '0;
        for (int p = 0; p < NW; p++) begin
          hit[p] = we[p] && waddr[p*AW +: AW] == AW'(i) && wbe[p*NB + b];
          d[p] = wdata[p*N + b*BW +: BW];
        end
        lane = resolve_writes(hit, d);
        nxt[i][b*BW +: BW] = merge_bytes(mem[i][b*BW +: BW], lane.data, lane.en);
      end
      if (ZERO_REG != 0 && i == 0) nxt[i] = '0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) mem <= '{default: '0};
    else mem <= nxt;
  always_comb begin
    val = '0;
    rb = '0;
    a = '0;
    for (int r = 0; r < NR; r++) begin
      a = raddr[r*AW +: AW];
      if ({1'b0, a} < MV && !(ZERO_REG != 0 && a == '0)) val[r*N +: N] = BYPASS != 0 ? nxt[a] : mem[a];
      if ({1'b0, a} < MV) rb[r] = BYPASS != 0 ? busy_nxt[a] : busy[a];
    end
  end
  if (READ_REG != 0) begin : g_reg
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        rdata <= '0;
        rvalid <= '0;
        rbusy <= '0;
      end else begin
        rvalid <= re;
        rbusy <= rb & re;
        for (int r = 0; r < NR; r++) if (re[r]) rdata[r*N +: N] <= val[r*N +: N];
      end
  end else begin : g_comb
    always_comb begin
      rdata = rst ? '0 : val;
      rvalid = rst ? '0 : re;
      rbusy = rst ? '0 : rb;
    end
  end
endmodule

// File: tb/tb_reg_file_mwnr.sv
// tb_reg_file_mwnr: scoreboard bench driving a bypass/M=8 instance and a no-bypass/zero-reg/M=6 instance
module tb_reg_file_mwnr;
  logic        clk = 0;
  logic        rst = 1;
  logic [1:0]  we = '0;
  logic [5:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wbe = '0;
  logic [1:0]  re = '0;
  logic [5:0]  raddr = '0;
  logic        alloc = 0;
  logic [2:0]  alloc_addr = '0;
  logic [31:0] rdata_a, rdata_b;
  logic [1:0]  rvalid_a, rvalid_b, rbusy_a, rbusy_b;
  logic [7:0]  busy_a;
  logic [5:0]  busy_b;
  logic [16:0] q[2][2][$];
  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  reg_file_mwnr #(.M(8), .N(16), .NR(2), .NW(2), .READ_REG(1), .BYPASS(1), .ZERO_REG(0)) u_a (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe), .re(re), .raddr(raddr),
    .rdata(rdata_a), .rvalid(rvalid_a), .rbusy(rbusy_a), .alloc(alloc), .alloc_addr(alloc_addr), .busy(busy_a)
  );
  reg_file_mwnr #(.M(6), .N(16), .NR(2), .NW(2), .READ_REG(1), .BYPASS(0), .ZERO_REG(1)) u_b (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe), .re(re), .raddr(raddr),
    .rdata(rdata_b), .rvalid(rvalid_b), .rbusy(rbusy_b), .alloc(alloc), .alloc_addr(alloc_addr), .busy(busy_b)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", n, act, exp);
    else passed++;
  endtask

  task automatic wr(input int p, input logic [2:0] a, input logic [15:0] dt, input logic [1:0] be);
    we[p] = 1'b1;
    waddr[p*3 +: 3] = a;
    wdata[p*16 +: 16] = dt;
    wbe[p*2 +: 2] = be;
  endtask

  task automatic rd(input int p, input logic [2:0] a, input logic [16:0] ea, input logic [16:0] eb);
    re[p] = 1'b1;
    raddr[p*3 +: 3] = a;
    q[0][p].push_back(ea);
    q[1][p].push_back(eb);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    we = '0; waddr = '0; wdata = '0; wbe = '0;
    re = '0; raddr = '0; alloc = 0; alloc_addr = '0;
  endtask

  always @(negedge clk) begin : mon
    logic v;
    logic [16:0] act, exp;
    for (int dd = 0; dd < 2; dd++)
      for (int r = 0; r < 2; r++) begin
        v = dd == 0 ? rvalid_a[r] : rvalid_b[r];
        act = dd == 0 ? {rbusy_a[r], rdata_a[r*16 +: 16]} : {rbusy_b[r], rdata_b[r*16 +: 16]};
        if (v) begin
          if (q[dd][r].size() == 0) begin
            total++;
            $display("FAIL unexpected_rvalid dut%0d port%0d: got %h with no read pending", dd, r, act);
          end else begin
            exp = q[dd][r].pop_front();
            chk($sformatf("read dut%0d port%0d {rbusy,rdata}", dd, r), 32'(act), 32'(exp));
          end
        end
      end
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset rdata_a", rdata_a, 32'h0);
    chk("reset rvalid_a", 32'(rvalid_a), 32'h0);
    chk("reset busy_a", 32'(busy_a), 32'h0);
    chk("reset busy_b", 32'(busy_b), 32'h0);
    @(posedge clk);
    #1 rst = 0;
    wr(0, 3, 16'hA5A5, 2'b11); tick();
    rd(0, 3, 17'h0A5A5, 17'h0A5A5); tick();
    wr(0, 2, 16'h1111, 2'b11); wr(1, 2, 16'h2200, 2'b10); rd(1, 2, 17'h02211, 17'h00000); tick();
    rd(0, 2, 17'h02211, 17'h02211); tick();
    wr(0, 5, 16'h0F0F, 2'b11); tick();
    wr(0, 5, 16'hFF00, 2'b10); rd(0, 5, 17'h0FF0F, 17'h00F0F); tick();
    rd(1, 5, 17'h0FF0F, 17'h0FF0F); tick();
    alloc = 1; alloc_addr = 4; tick();
    chk("alloc busy_a", 32'(busy_a), 32'h10);
    chk("alloc busy_b", 32'(busy_b), 32'h10);
    rd(0, 4, 17'h10000, 17'h10000); tick();
    wr(0, 4, 16'h1234, 2'b00); tick();
    chk("clear busy_a", 32'(busy_a), 32'h0);
    chk("clear busy_b", 32'(busy_b), 32'h0);
    alloc = 1; alloc_addr = 4; wr(1, 4, 16'h00FF, 2'b01); rd(0, 4, 17'h100FF, 17'h00000); tick();
    chk("alloc+write busy_a", 32'(busy_a), 32'h10);
    chk("alloc+write busy_b", 32'(busy_b), 32'h10);
    wr(0, 0, 16'hFFFF, 2'b11); alloc = 1; alloc_addr = 0; tick();
    chk("reg0 busy_a", 32'(busy_a), 32'h11);
    chk("reg0 busy_b", 32'(busy_b), 32'h10);
    rd(0, 0, 17'h1FFFF, 17'h00000); tick();
    wr(0, 7, 16'hBEEF, 2'b11); alloc = 1; alloc_addr = 6; tick();
    chk("range busy_a", 32'(busy_a), 32'h51);
    chk("range busy_b", 32'(busy_b), 32'h10);
    rd(0, 7, 17'h0BEEF, 17'h00000); rd(1, 6, 17'h10000, 17'h00000); tick();
    rd(0, 3, 17'h0A5A5, 17'h0A5A5); rd(1, 5, 17'h0FF0F, 17'h0FF0F); tick();
    tick();
    chk("idle rvalid_a", 32'(rvalid_a), 32'h0);
    chk("idle rbusy_a", 32'(rbusy_a), 32'h0);
    chk("hold rdata_a", rdata_a, 32'hFF0FA5A5);
    chk("hold rdata_b", rdata_b, 32'hFF0FA5A5);
    rd(0, 4, 17'h100FF, 17'h100FF); tick();
    @(negedge clk);
    #1 rst = 1;
    #1;
    chk("async rst rdata_a", rdata_a, 32'h0);
    chk("async rst rdata_b", rdata_b, 32'h0);
    chk("async rst rvalid_a", 32'(rvalid_a), 32'h0);
    chk("async rst rbusy_b", 32'(rbusy_b), 32'h0);
    chk("async rst busy_a", 32'(busy_a), 32'h0);
    chk("async rst busy_b", 32'(busy_b), 32'h0);
    re = 2'b01; raddr = 6'd3;
    @(posedge clk);
    #1 rst = 0; re = '0; raddr = '0;
    rd(0, 3, 17'h00000, 17'h00000); tick();
    tick();
    tick();
    for (int dd = 0; dd < 2; dd++)
      for (int r = 0; r < 2; r++) chk($sformatf("drain dut%0d port%0d", dd, r), 32'(q[dd][r].size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/reg_file_mwnr.md
Name: reg_file_mwnr

Overview:
- Parametrised multi-write, multi-read register file; the next generation of the team's 1W/2R register file.
- Adds asynchronous reset, NW write ports with byte enables and fixed write-port priority, and NR read ports with an optional registered output stage.
- Adds write-to-read bypass, an optional hardwired-zero register 0, and a per-register busy scoreboard.
- Sits between issue/decode (alloc, reads) and writeback (writes) in the team's datapath blocks.

Parameters:
- M, 8: number of registers (any value >= 2; AW = $clog2(M)).
- N, 8: register width in bits; must be a multiple of 8 (NB = N/8 byte lanes).
- NR, 2: number of read ports.
- NW, 2: number of write ports.
- READ_REG, 1: 1 = registered read (1-cycle latency), 0 = combinational read.
- BYPASS, 1: 1 = same-cycle write data forwarded to reads, 0 = reads return the pre-write value.
- ZERO_REG, 0: 1 = register 0 always reads 0; writes and alloc to it are ignored.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- we  input  NW  per-port write enable.
- waddr  input  NW*AW  write addresses; port p at [p*AW +: AW].
- wdata  input  NW*N  write data; port p at [p*N +: N].
- wbe  input  NW*NB  byte enables; port p at [p*NB +: NB].
- re  input  NR  per-port read enable.
- raddr  input  NR*AW  read addresses.
- rdata  output  NR*N  read data.
- rvalid  output  NR  read data valid.
- rbusy  output  NR  busy state of the register being read, aligned with rdata.
- alloc  input  1  mark a register busy (a write is pending).
- alloc_addr  input  AW  register to mark busy.
- busy  output  M  scoreboard bit vector.

Behaviour:
Reset
- Clock is clk; reset is rst, asynchronous and active-high.
- While rst is high, immediately: all registers = 0, busy = 0, rdata = 0, rvalid = 0, rbusy = 0.
- An in-flight registered read is dropped.
- The first edge after rst deasserts behaves normally.

Write
- On each edge, for each port p with we[p] and waddr < M, and for each byte b with wbe[p][b]=1: reg[waddr][b] <= wdata[p][b].
- If several ports write the same byte of the same register, the highest-index port wins, per byte.
- Out-of-range waddr (when M is not a power of 2): write ignored.
- ZERO_REG=1: writes to address 0 are ignored.

Read, READ_REG=1
- re[r] sampled at edge k gives rdata[r]/rvalid[r]=1 from edge k onward for one cycle (1-cycle latency).
- With re[r]=0: rvalid[r]=0 and rdata[r] holds its last value.

Read, READ_REG=0
- rdata[r] is combinational from raddr[r]; rvalid[r] = re[r].

Bypass
- BYPASS=1: if a write to raddr[r] occurs in the read's cycle, rdata is the merged post-write value: winning-writer bytes where enabled, old bytes elsewhere.
- BYPASS=0: the old value is returned.

Read boundaries
- Out-of-range raddr reads 0.
- ZERO_REG=1: address 0 reads 0.

Scoreboard
- alloc with a valid alloc_addr sets busy[alloc_addr] at the edge.
- Any we[p] to a valid address clears busy[waddr[p]] at the edge, regardless of wbe.
- Alloc and write to the same register in one cycle: alloc wins, so busy = 1.
- ZERO_REG=1: busy[0] is always 0.

rbusy
- rbusy[r] = busy[raddr[r]], timed like rdata: registered when READ_REG=1, combinational otherwise.
- When BYPASS=1, the clear/set from the same cycle is applied before sampling.
- rbusy[r] is 0 when rvalid[r] is 0 (READ_REG=1) or when raddr is out of range.

Decomposition:
- Package reg_file_pkg holds:
  - the byte-lane width constant (8);
  - a function merge_bytes(old, new, be) for byte-enable merge;
  - a function resolve_writes that returns per-byte winning data/enable for one address from the flattened write ports.
- Sub-module reg_file_scoreboard holds the M-bit busy vector with alloc/clear logic and the ZERO_REG masking.
- Storage, read muxing and bypass stay in the top module.

Test Plan:
- Reset/basic (M=8, N=16, READ_REG=1):
  - assert rst;
  - write reg3=16'hA5A5 with wbe=2'b11, read reg3 next cycle -> rdata=16'hA5A5, rvalid=1 one cycle later;
  - assert rst -> rdata=0, busy=0 immediately.
- Byte enables and priority:
  - port0 writes reg2=16'h1111 (wbe 2'b11) and port1 writes reg2=16'h2200 (wbe 2'b10) in the same cycle -> reg2=16'h2211.
- Bypass:
  - reg5=16'h0F0F; in one cycle write reg5=16'hFF00 with wbe=2'b10 and read reg5 -> BYPASS=1 gives 16'hFF0F, BYPASS=0 gives 16'h0F0F.
- Scoreboard:
  - alloc reg4 -> busy[4]=1 and a read of reg4 gives rbusy=1;
  - write reg4 -> busy[4]=0;
  - alloc reg4 and write reg4 in the same cycle -> busy[4]=1.
- Zero register (ZERO_REG=1):
  - write reg0=16'hFFFF and alloc reg0 -> reads 0, busy[0]=0.
- Out of range (M=6):
  - write addr 7 -> no register changes;
  - read addr 6 -> rdata=0, rbusy=0.
